frame_energy_det: RTL and testbench
===================================

Name: frame_energy_det

Overview:
Downstream consumer of the DC-removal (sub-mean) stage in the beamforming chain. Takes the zero-mean signed sample stream plus its valid strobe and accumulates sum-of-squares energy and peak magnitude over fixed non-overlapping frames. Applies a hysteresis threshold to give an activity flag. Energy and detect outputs feed the channel-select / direction-estimation logic.

Parameters:
DATA_WIDTH, 16, sample width; two's-complement signed.
LOG2_FRAME, 8, log2 of frame length; FRAME_LEN = 2**LOG2_FRAME = 256 samples.
ACC_WIDTH, 2*DATA_WIDTH+LOG2_FRAME (40), energy accumulator/output width; derived, not overridden.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
sample_in  in  DATA_WIDTH  signed zero-mean sample from sub-mean stage
sample_valid  in  1  sample_in qualifier; 1-cycle strobes, arbitrary gaps allowed
restart  in  1  synchronous frame restart; discards partial frame
thresh_on  in  ACC_WIDTH  detect set level (unsigned)
thresh_off  in  ACC_WIDTH  detect clear level (unsigned); thresh_off <= thresh_on required
energy_out  out  ACC_WIDTH  sum of squares of last completed frame (unsigned)
peak_out  out  DATA_WIDTH  max |sample| of last completed frame (unsigned)
energy_valid  out  1  1-cycle pulse when energy_out/peak_out update
detect  out  1  hysteresis activity flag

Behaviour:
- Reset (async): all pipeline valids 0, sample counter 0, accumulator 0, running peak 0, energy_out 0, peak_out 0, energy_valid 0, detect 0.
- Stage 1 (S1): on sample_valid, register sample and abs value. abs width DATA_WIDTH unsigned; abs(-32768) = 32768, no saturation.
- Stage 2 (S2): square = abs*abs, 2*DATA_WIDTH unsigned; max 2^30, no overflow.
- Stage 3 (S3): accumulate, update peak, increment counter (LOG2_FRAME bits, wraps).
- On the S3 sample with counter == FRAME_LEN-1:
  - energy_out <= acc + square; peak_out <= max(peak, abs); energy_valid = 1 next cycle.
  - acc and peak reset to 0; counter wraps to 0.
- Next frame's first S3 sample in the cycle right after a boundary: loads square/abs directly. No dead cycle, no sample lost.
- Latency: energy_valid is asserted 3 clk edges after the edge capturing the frame's last sample_valid. energy_out/peak_out hold until the next frame completes.
- Overflow impossible: FRAME_LEN*2^30 < 2^ACC_WIDTH.
- Detect:
  - Evaluated only in the cycle energy_out updates, using the new value.
  - 0->1 when energy >= thresh_on; 1->0 when energy < thresh_off; else hold.
  - detect changes in the same cycle energy_valid is high.
- restart:
  - Clears S1/S2/S3 valids, counter, acc and running peak at the next edge.
  - energy_out, peak_out and detect are held; no energy_valid generated.
  - sample_valid in the same cycle as restart is accepted as sample 0 of the new frame.
  - restart in the same cycle as a frame-completing S3 sample: restart wins; no energy_valid, frame discarded.
- Gaps in sample_valid stall nothing: valids propagate independently; counter advances only on valid S3 samples.
- Reset mid-frame: partial frame discarded; outputs return to reset values immediately.

Decomposition:
- Shared package beamform_pkg:
  - DATA_WIDTH, LOG2_FRAME, ACC_WIDTH derivation function.
  - Typedefs sample_t (signed) and energy_t.
  - Reuse the existing sample width constant used by the sub-mean stage.
- One sub-module, abs_square: registered S1+S2 (abs + square, 2-cycle latency, valid passthrough, restart flush).
- Top holds S3, counter, output registers and hysteresis FSM (IDLE/ACTIVE).

Test Plan:
- 256 valid samples of +100, back-to-back -> one energy_valid pulse; energy_out=2,560,000, peak_out=100; detect=1 with thresh_on=1,000,000.
- 256 samples of -32768 with random 0-5 cycle gaps -> energy_out=2^38 (274,877,906,944), peak_out=32768; pulse 3 cycles after last valid.
- Frame A all +100, frame B contiguous all 0, with thresh_on=1,000,000, thresh_off=500,000 -> detect 1 after A; 0 after B; energy_out=0 after B, peak_out=0.
- Hysteresis hold: energy 700,000 while detect=1 -> stays 1; energy 700,000 from detect=0 -> stays 0.
- restart after 100 samples of +50, then 256 samples of +10 -> single pulse, energy_out=25,600, peak_out=10; no pulse from the aborted frame.
- Async reset asserted mid-frame (sample 130) -> all outputs 0 immediately; next 256 samples produce a correct fresh frame.

Source files
------------

// File: rtl/beamform_pkg.sv
// Shared constants and types for the beamforming chain.
// Widths here track the DC-removal stage so downstream blocks stay in step with it.
package beamform_pkg;

  // Sample width produced by the sub-mean stage.
  localparam int unsigned SUBMEAN_DATA_WIDTH = 16;

  localparam int unsigned DATA_WIDTH = SUBMEAN_DATA_WIDTH;
  localparam int unsigned LOG2_FRAME = 8;

  // Square doubles the width; summing 2**lf of them adds lf bits of headroom.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned lf);
    return 2 * dw + lf;
  endfunction

  localparam int unsigned ACC_WIDTH = acc_width(DATA_WIDTH, LOG2_FRAME);

  typedef logic signed [DATA_WIDTH-1:0] sample_t;
  typedef logic        [ACC_WIDTH-1:0]  energy_t;

  typedef enum logic [0:0] {
    StIdle,
    StActive
  } det_state_e;

endpackage

// File: rtl/abs_square.sv
// Two-stage registered magnitude and square of a signed sample stream.
// S1 registers |x|, S2 registers |x|^2; restart flushes anything already in flight.
module abs_square #(
  parameter int unsigned DATA_WIDTH = beamform_pkg::DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          restart,
  input  logic                          in_valid,
  input  logic signed [DATA_WIDTH-1:0]  in_sample,
  output logic                          out_valid,
  output logic        [DATA_WIDTH-1:0]  out_abs,
  output logic        [2*DATA_WIDTH-1:0] out_square
);

  logic                    s1_valid_d, s1_valid_q;
  logic [DATA_WIDTH-1:0]   s1_abs_d, s1_abs_q;
  logic                    s2_valid_d, s2_valid_q;
  logic [DATA_WIDTH-1:0]   s2_abs_d, s2_abs_q;
  logic [2*DATA_WIDTH-1:0] s2_square_d, s2_square_q;
  logic [2*DATA_WIDTH-1:0] s1_abs_wide;

  assign s1_abs_wide = {{DATA_WIDTH{1'b0}}, s1_abs_q};

  always_comb begin
    // A sample arriving alongside restart belongs to the new frame, so S1 keeps it.
    s1_valid_d  = in_valid;
    s1_abs_d    = s1_abs_q;
    s2_valid_d  = restart ? 1'b0 : s1_valid_q;
    s2_abs_d    = s2_abs_q;
    s2_square_d = s2_square_q;

    // Unsigned reinterpretation makes |-2**(W-1)| come out as 2**(W-1) without saturating.
    if (in_valid) begin
      s1_abs_d = in_sample[DATA_WIDTH-1] ? (~in_sample + 1'b1) : in_sample;
    end
    if (s1_valid_q) begin
      s2_abs_d    = s1_abs_q;
      s2_square_d = s1_abs_wide * s1_abs_wide;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_abs_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_abs_q    <= '0;
      s2_square_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_abs_q    <= s1_abs_d;
      s2_valid_q  <= s2_valid_d;
      s2_abs_q    <= s2_abs_d;
      s2_square_q <= s2_square_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_abs    = s2_abs_q;
  assign out_square = s2_square_q;

endmodule

// File: rtl/frame_energy_det.sv
// Frame energy / peak accumulator with hysteresis activity detect.
// Sums squares and tracks max |x| over non-overlapping 2**LOG2_FRAME-sample frames.
module frame_energy_det #(
  parameter  int unsigned DATA_WIDTH = beamform_pkg::DATA_WIDTH,
  parameter  int unsigned LOG2_FRAME = beamform_pkg::LOG2_FRAME,
  localparam int unsigned ACC_WIDTH  = beamform_pkg::acc_width(DATA_WIDTH, LOG2_FRAME)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  input  logic                         sample_valid,
  input  logic                         restart,
  input  logic        [ACC_WIDTH-1:0]  thresh_on,
  input  logic        [ACC_WIDTH-1:0]  thresh_off,
  output logic        [ACC_WIDTH-1:0]  energy_out,
  output logic        [DATA_WIDTH-1:0] peak_out,
  output logic                         energy_valid,
  output logic                         detect
);

  import beamform_pkg::det_state_e;
  import beamform_pkg::StIdle;
  import beamform_pkg::StActive;

  logic                    s2_valid;
  logic [DATA_WIDTH-1:0]   s2_abs;
  logic [2*DATA_WIDTH-1:0] s2_square;

  abs_square #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_abs_square (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .in_valid  (sample_valid),
    .in_sample (sample_in),
    .out_valid (s2_valid),
    .out_abs   (s2_abs),
    .out_square(s2_square)
  );

  logic                    s3_valid_d, s3_valid_q;
  logic [DATA_WIDTH-1:0]   s3_abs_d, s3_abs_q;
  logic [2*DATA_WIDTH-1:0] s3_square_d, s3_square_q;
  logic [LOG2_FRAME-1:0]   cnt_d, cnt_q;
  logic [ACC_WIDTH-1:0]    acc_d, acc_q;
  logic [DATA_WIDTH-1:0]   peak_d, peak_q;
  logic [ACC_WIDTH-1:0]    energy_d, energy_q;
  logic [DATA_WIDTH-1:0]   peak_out_d, peak_out_q;
  logic                    energy_valid_d, energy_valid_q;
  det_state_e              state_d, state_q;

  logic [ACC_WIDTH-1:0]    frame_sum;
  logic [DATA_WIDTH-1:0]   frame_peak;

  // Running totals including the S3 sample; used both to accumulate and to close a frame.
  assign frame_sum  = acc_q + {{LOG2_FRAME{1'b0}}, s3_square_q};
  assign frame_peak = (s3_abs_q > peak_q) ? s3_abs_q : peak_q;

  always_comb begin
    s3_valid_d     = s2_valid;
    s3_abs_d       = s3_abs_q;
    s3_square_d    = s3_square_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    peak_d         = peak_q;
    energy_d       = energy_q;
    peak_out_d     = peak_out_q;
    energy_valid_d = 1'b0;
    state_d        = state_q;

    if (s2_valid) begin
      s3_abs_d    = s2_abs;
      s3_square_d = s2_square;
    end

    if (restart) begin
      // Restart beats a frame-completing sample: the frame is dropped, outputs hold.
      s3_valid_d = 1'b0;
      cnt_d      = '0;
      acc_d      = '0;
      peak_d     = '0;
    end else if (s3_valid_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        // Clearing here lets the next frame's first sample load straight into acc.
        acc_d          = '0;
        peak_d         = '0;
        energy_d       = frame_sum;
        peak_out_d     = frame_peak;
        energy_valid_d = 1'b1;
        unique case (state_q)
          StIdle:   if (frame_sum >= thresh_on)  state_d = StActive;
          StActive: if (frame_sum <  thresh_off) state_d = StIdle;
          default:  state_d = StIdle;
        endcase
      end else begin
        acc_d  = frame_sum;
        peak_d = frame_peak;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3_valid_q     <= 1'b0;
      s3_abs_q       <= '0;
      s3_square_q    <= '0;
      cnt_q          <= '0;
      acc_q          <= '0;
      peak_q         <= '0;
      energy_q       <= '0;
      peak_out_q     <= '0;
      energy_valid_q <= 1'b0;
      state_q        <= StIdle;
    end else begin
      s3_valid_q     <= s3_valid_d;
      s3_abs_q       <= s3_abs_d;
      s3_square_q    <= s3_square_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      peak_q         <= peak_d;
      energy_q       <= energy_d;
      peak_out_q     <= peak_out_d;
      energy_valid_q <= energy_valid_d;
      state_q        <= state_d;
    end
  end

  assign energy_out   = energy_q;
  assign peak_out     = peak_out_q;
  assign energy_valid = energy_valid_q;
  assign detect       = (state_q == StActive);

endmodule

// File: tb/tb_frame_energy_det.sv
// Bench for frame_energy_det: table of whole frames plus hand-built restart/reset/gap cases.
// Expected frame results are queued as the last sample is driven and checked on energy_valid.
module tb_frame_energy_det;

  localparam int unsigned DW    = 16;
  localparam int unsigned LF    = 8;
  localparam int unsigned AW    = 2 * DW + LF;
  localparam int          FRAME = 1 << LF;

  logic                 clk = 1'b0;
  logic                 reset;
  logic signed [DW-1:0] sample_in;
  logic                 sample_valid;
  logic                 restart;
  logic [AW-1:0]        thresh_on;
  logic [AW-1:0]        thresh_off;
  logic [AW-1:0]        energy_out;
  logic [DW-1:0]        peak_out;
  logic                 energy_valid;
  logic                 detect;

  frame_energy_det #(
    .DATA_WIDTH(DW),
    .LOG2_FRAME(LF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .restart     (restart),
    .thresh_on   (thresh_on),
    .thresh_off  (thresh_off),
    .energy_out  (energy_out),
    .peak_out    (peak_out),
    .energy_valid(energy_valid),
    .detect      (detect)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint energy;
    longint peak;
    bit     det;
    int     cyc;
  } exp_t;

  typedef struct {
    int     v_main;
    int     v_last;
    longint on;
    longint off;
    longint energy;
    longint peak;
    bit     det;
  } vec_t;

  exp_t exp_q[$];
  exp_t got;
  int   n_cmp   = 0;
  int   n_fail  = 0;
  int   n_pulse = 0;
  bit   det_model;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit next_det(input bit cur, input longint e, input longint on,
                                  input longint off);
    return cur ? (e >= off) : (e >= on);
  endfunction

  task automatic push_exp(input longint e, input longint pk, input bit det);
    exp_t x;
    x.energy = e;
    x.peak   = pk;
    x.det    = det;
    x.cyc    = cyc + 3;
    exp_q.push_back(x);
    det_model = det;
  endtask

  task automatic step(input bit v, input int val, input bit rs);
    sample_valid = v;
    sample_in    = val[DW-1:0];
    restart      = rs;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    restart      = 1'b0;
  endtask

  task automatic run_frame(input int vm, input int vl, input int gap_max, input bit rs_first,
                           input longint on, input longint off);
    for (int i = 0; i < FRAME; i++) begin
      if (i == FRAME / 2) begin
        thresh_on  = AW'(on);
        thresh_off = AW'(off);
      end
      if (i > 0) repeat ($urandom_range(gap_max, 0)) step(1'b0, 0, 1'b0);
      step(1'b1, (i == FRAME - 1) ? vl : vm, rs_first && (i == 0));
    end
  endtask

  always @(negedge clk) begin
    if (energy_valid) begin
      n_pulse++;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        got = exp_q.pop_front();
        check("energy_out", energy_out, got.energy);
        check("peak_out", peak_out, got.peak);
        check("detect", detect, got.det);
        check("pulse_cycle", cyc, got.cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  vec_t vecs[10];
  int   p0;

  initial begin
    vecs[0] = '{100,    100,    1000000, 500000,  2560000,    100,   1'b1};
    vecs[1] = '{0,      0,      1000000, 500000,  0,          0,     1'b0};
    vecs[2] = '{50,     250,    1000000, 500000,  700000,     250,   1'b0};
    vecs[3] = '{100,    100,    1000000, 500000,  2560000,    100,   1'b1};
    vecs[4] = '{50,     250,    1000000, 500000,  700000,     250,   1'b1};
    vecs[5] = '{-7,     -300,   1000000, 500000,  102495,     300,   1'b0};
    vecs[6] = '{1000,   -32768, 1000000, 500000,  1328741824, 32768, 1'b1};
    vecs[7] = '{100,    100,    2560001, 2560000, 2560000,    100,   1'b1};
    vecs[8] = '{50,     250,    2560001, 2560000, 700000,     250,   1'b0};
    vecs[9] = '{100,    100,    2560000, 0,       2560000,    100,   1'b1};

    reset        = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    restart      = 1'b0;
    thresh_on    = AW'(1000000);
    thresh_off   = AW'(500000);
    det_model    = 1'b0;
    #12;
    check("reset_energy_out", energy_out, 0);
    check("reset_peak_out", peak_out, 0);
    check("reset_energy_valid", energy_valid, 0);
    check("reset_detect", detect, 0);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back frames from the table.
    foreach (vecs[k]) begin
      run_frame(vecs[k].v_main, vecs[k].v_last, 0, 1'b0, vecs[k].on, vecs[k].off);
      push_exp(vecs[k].energy, vecs[k].peak, vecs[k].det);
    end
    repeat (6) step(1'b0, 0, 1'b0);
    thresh_on  = AW'(1000000);
    thresh_off = AW'(500000);

    // Full-scale negative samples with random gaps.
    run_frame(-32768, -32768, 5, 1'b0, 1000000, 500000);
    push_exp(64'd274877906944, 32768, next_det(det_model, 64'd274877906944, 1000000, 500000));
    repeat (6) step(1'b0, 0, 1'b0);

    // Restart after 100 samples; restart coincides with sample 0 of the new frame.
    p0 = n_pulse;
    for (int i = 0; i < 100; i++) step(1'b1, 50, 1'b0);
    run_frame(10, 10, 0, 1'b1, 1000000, 500000);
    push_exp(25600, 10, next_det(det_model, 25600, 1000000, 500000));
    repeat (6) step(1'b0, 0, 1'b0);
    check("restart_pulse_count", n_pulse, p0 + 1);

    // Restart lands on the frame-completing S3 sample: no pulse, frame dropped.
    p0 = n_pulse;
    run_frame(20, 20, 0, 1'b0, 1000000, 500000);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b1);
    repeat (6) step(1'b0, 0, 1'b0);
    check("restart_wins_pulse_count", n_pulse, p0);
    check("restart_wins_energy_hold", energy_out, 25600);
    run_frame(10, 10, 0, 1'b0, 1000000, 500000);
    push_exp(25600, 10, next_det(det_model, 25600, 1000000, 500000));
    repeat (6) step(1'b0, 0, 1'b0);

    // Establish non-zero outputs, then reset mid-frame.
    run_frame(100, 100, 0, 1'b0, 1000000, 500000);
    push_exp(2560000, 100, next_det(det_model, 2560000, 1000000, 500000));
    repeat (6) step(1'b0, 0, 1'b0);
    for (int i = 0; i < 130; i++) step(1'b1, 100, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("midreset_energy_out", energy_out, 0);
    check("midreset_peak_out", peak_out, 0);
    check("midreset_energy_valid", energy_valid, 0);
    check("midreset_detect", detect, 0);
    det_model = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    step(1'b0, 0, 1'b0);
    run_frame(100, 100, 0, 1'b0, 1000000, 500000);
    push_exp(2560000, 100, next_det(det_model, 2560000, 1000000, 500000));

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1'b0, 0, 1'b0);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
